// File: rtl/add_num_wr_issuer.sv
// Issues one CCI-P c1 write per accepted result and waits for its tagged response before
// reporting done; one write in flight at a time, requests are held off while c1TxAlmFull is high.
module add_num_wr_issuer #(
  parameter int ADDR_W  = 42,
  parameter int RES_W   = 8,
  parameter int CL_W    = 512,
  parameter int MDATA_W = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [RES_W-1:0]   res_data,
  input  logic [ADDR_W-1:0]  res_addr,
  input  logic               c1_alm_full,
  output logic               c1_tx_valid,
  output logic [ADDR_W-1:0]  c1_tx_addr,
  output logic               c1_tx_sop,
  output logic [MDATA_W-1:0] c1_tx_mdata,
  output logic [CL_W-1:0]    c1_tx_data,
  input  logic               c1_rsp_valid,
  input  logic [MDATA_W-1:0] c1_rsp_mdata,
  input  logic               clear_err,
  output logic               done,
  output logic               err_timeout,
  output logic               err_stray
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t             state;
  logic [MDATA_W-1:0] tag;
  logic [CNT_W-1:0]   wait_cnt;
  logic [RES_W-1:0]   cap_res;
  logic [ADDR_W-1:0]  cap_addr;

  logic rsp_match;
  logic stray_evt;
  logic timeout_evt;

  // A match on the last counter value beats the timeout.
  always_comb begin
    rsp_match   = c1_rsp_valid && (state == WAIT_RSP) && (c1_rsp_mdata == tag);
    stray_evt   = c1_rsp_valid && !rsp_match;
    timeout_evt = (state == WAIT_RSP) && !rsp_match && (wait_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tag         <= '0;
      wait_cnt    <= '0;
      cap_res     <= '0;
      cap_addr    <= '0;
      res_ready   <= 1'b0;
      c1_tx_valid <= 1'b0;
      c1_tx_sop   <= 1'b0;
      c1_tx_addr  <= '0;
      c1_tx_mdata <= '0;
      c1_tx_data  <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      c1_tx_valid <= 1'b0;
      c1_tx_sop   <= 1'b0;
      done        <= 1'b0;

      // Sticky flags: a new error event in the clearing cycle keeps the flag set.
      if (stray_evt)
        err_stray <= 1'b1;
      else if (clear_err)
        err_stray <= 1'b0;

      if (timeout_evt)
        err_timeout <= 1'b1;
      else if (clear_err)
        err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (res_valid && res_ready) begin
            cap_res   <= res_data;
            cap_addr  <= res_addr;
            res_ready <= 1'b0;
            state     <= ISSUE;
          end else begin
            res_ready <= 1'b1;
          end
        end

        ISSUE: begin
          if (!c1_alm_full) begin
            c1_tx_valid <= 1'b1;
            c1_tx_sop   <= 1'b1;
            c1_tx_addr  <= cap_addr;
            c1_tx_mdata <= tag;
            c1_tx_data  <= {{(CL_W-RES_W){1'b0}}, cap_res};
            wait_cnt    <= '0;
            state       <= WAIT_RSP;
          end
        end

        WAIT_RSP: begin
          if (rsp_match || timeout_evt) begin
            done      <= 1'b1;
            res_ready <= 1'b1;
            tag       <= tag + MDATA_W'(1);
            wait_cnt  <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_num_wr_issuer.sv
// Directed bench for add_num_wr_issuer with a queue-based scoreboard for write requests and done pulses.
module tb_add_num_wr_issuer;

  localparam int ADDR_W  = 42;
  localparam int RES_W   = 8;
  localparam int CL_W    = 512;
  localparam int MDATA_W = 2;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               res_valid = 1'b0;
  logic               res_ready;
  logic [RES_W-1:0]   res_data = '0;
  logic [ADDR_W-1:0]  res_addr = '0;
  logic               c1_alm_full = 1'b0;
  logic               c1_tx_valid;
  logic [ADDR_W-1:0]  c1_tx_addr;
  logic               c1_tx_sop;
  logic [MDATA_W-1:0] c1_tx_mdata;
  logic [CL_W-1:0]    c1_tx_data;
  logic               c1_rsp_valid = 1'b0;
  logic [MDATA_W-1:0] c1_rsp_mdata = '0;
  logic               clear_err = 1'b0;
  logic               done;
  logic               err_timeout;
  logic               err_stray;

  add_num_wr_issuer #(
    .ADDR_W(ADDR_W), .RES_W(RES_W), .CL_W(CL_W), .MDATA_W(MDATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_addr(res_addr),
    .c1_alm_full(c1_alm_full),
    .c1_tx_valid(c1_tx_valid), .c1_tx_addr(c1_tx_addr), .c1_tx_sop(c1_tx_sop),
    .c1_tx_mdata(c1_tx_mdata), .c1_tx_data(c1_tx_data),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .clear_err(clear_err), .done(done), .err_timeout(err_timeout), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [RES_W-1:0]   res;
    logic [MDATA_W-1:0] mdata;
    int                 cyc;
  } tx_exp_t;

  typedef struct {
    int   cyc;
    logic err;
  } done_exp_t;

  tx_exp_t   tx_q[$];
  done_exp_t done_q[$];

  int nvec = 0;
  int nerr = 0;
  logic [MDATA_W-1:0] exp_tag = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_res_ready"},   64'(res_ready),   64'd0);
    chk({pfx, "_tx_valid"},    64'(c1_tx_valid), 64'd0);
    chk({pfx, "_tx_sop"},      64'(c1_tx_sop),   64'd0);
    chk({pfx, "_tx_addr"},     64'(c1_tx_addr),  64'd0);
    chk({pfx, "_tx_mdata"},    64'(c1_tx_mdata), 64'd0);
    chk({pfx, "_tx_data_or"},  64'(|c1_tx_data), 64'd0);
    chk({pfx, "_done"},        64'(done),        64'd0);
    chk({pfx, "_err_timeout"}, 64'(err_timeout), 64'd0);
    chk({pfx, "_err_stray"},   64'(err_stray),   64'd0);
  endtask

  // Offers one result; waits (bounded) for res_ready first. acc is the cycle the handshake completes in.
  task automatic write_req(input logic [ADDR_W-1:0] a, input logic [RES_W-1:0] d,
                           input bit blocked, output int acc);
    int n = 0;
    while (res_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("res_ready_wait", 64'(res_ready), 64'd1);
    res_valid = 1'b1;
    res_data  = d;
    res_addr  = a;
    acc = cyc;
    if (!blocked) tx_q.push_back('{a, d, exp_tag, acc + 2});
    step();
    res_valid = 1'b0;
    chk("res_ready_low_after_accept", 64'(res_ready), 64'd0);
  endtask

  task automatic send_rsp(input logic [MDATA_W-1:0] t, input bit match, input logic exp_err);
    c1_rsp_valid = 1'b1;
    c1_rsp_mdata = t;
    if (match) begin
      done_q.push_back('{cyc + 1, exp_err});
      exp_tag = exp_tag + MDATA_W'(1);
    end
    step();
    c1_rsp_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a request or a done pulse.
  always @(negedge clk) begin : mon
    tx_exp_t         e;
    done_exp_t       de;
    logic [CL_W-1:0] ed;
    if (reset_n) begin
      if (c1_tx_valid) begin
        if (tx_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL tx_unexpected: got c1_tx_valid=1 mdata=%0h, expected none (cycle %0d)", c1_tx_mdata, cyc);
        end else begin
          e = tx_q.pop_front();
          ed = '0;
          ed[RES_W-1:0] = e.res;
          chk("tx_cycle", 64'(cyc), 64'(e.cyc));
          chk("tx_addr",  64'(c1_tx_addr), 64'(e.addr));
          chk("tx_mdata", 64'(c1_tx_mdata), 64'(e.mdata));
          chk("tx_sop",   64'(c1_tx_sop), 64'd1);
          nvec++;
          if (c1_tx_data !== ed) begin
            nerr++;
            $display("FAIL tx_data: got %h, expected %h", c1_tx_data, ed);
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL done_unexpected: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          de = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(de.cyc));
          chk("done_err_timeout", 64'(err_timeout), 64'(de.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int d;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    #1;
    chk("res_ready_before_first_edge", 64'(res_ready), 64'd0);
    step();
    chk("res_ready_after_first_edge", 64'(res_ready), 64'd1);

    // Basic write, response 3 cycles after the request
    write_req(42'h1000, 8'h32, 1'b0, acc);
    repeat (4) step();
    send_rsp(2'd0, 1'b1, 1'b0);
    chk("res_ready_with_done", 64'(res_ready), 64'd1);
    write_req(42'h2040, 8'hA5, 1'b0, acc);
    step();
    step();
    send_rsp(2'd1, 1'b1, 1'b0);

    // Backpressure: 20 cycles of almost-full after acceptance
    c1_alm_full = 1'b1;
    write_req(42'h2AA_5555_0040, 8'hC3, 1'b1, acc);
    repeat (19) step();
    c1_alm_full = 1'b0;
    tx_q.push_back('{42'h2AA_5555_0040, 8'hC3, exp_tag, cyc + 1});
    step();
    send_rsp(2'd2, 1'b1, 1'b0);

    // Timeout: no response, done 16 cycles after the request
    write_req(42'h3000, 8'h7E, 1'b0, acc);
    done_q.push_back('{acc + 2 + TIMEOUT, 1'b1});
    exp_tag = exp_tag + MDATA_W'(1);
    repeat (20) step();
    chk("err_timeout_sticky", 64'(err_timeout), 64'd1);
    chk("res_ready_after_timeout", 64'(res_ready), 64'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("err_timeout_cleared", 64'(err_timeout), 64'd0);

    // Stray tag, then a match exactly on the last wait cycle (tag has wrapped to 0)
    write_req(42'h4000, 8'h11, 1'b0, acc);
    step();
    step();
    send_rsp(2'd2, 1'b0, 1'b0);
    chk("err_stray_mismatch", 64'(err_stray), 64'd1);
    chk("still_waiting_after_stray", 64'(res_ready), 64'd0);
    d = 0;
    while (cyc < acc + 2 + TIMEOUT - 1 && d < 40) begin
      step();
      d++;
    end
    send_rsp(2'd0, 1'b1, 1'b0);
    chk("race_err_timeout", 64'(err_timeout), 64'd0);
    chk("err_stray_held", 64'(err_stray), 64'd1);

    // Response in IDLE together with clear_err: the set wins
    clear_err = 1'b1;
    c1_rsp_valid = 1'b1;
    c1_rsp_mdata = exp_tag;
    step();
    clear_err = 1'b0;
    c1_rsp_valid = 1'b0;
    chk("stray_set_beats_clear", 64'(err_stray), 64'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("err_stray_cleared", 64'(err_stray), 64'd0);

    // Reset while waiting for a response
    write_req(42'h5000, 8'h22, 1'b0, acc);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("res_ready_after_midrst", 64'(res_ready), 64'd1);
    send_rsp(2'd1, 1'b0, 1'b0);
    chk("late_rsp_stray", 64'(err_stray), 64'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    write_req(42'h6000, 8'hFF, 1'b0, acc);
    step();
    step();
    send_rsp(2'd0, 1'b1, 1'b0);
    step();
    step();

    chk("tx_queue_drained", 64'(tx_q.size()), 64'd0);
    chk("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
